lif_neuron_ctrl: RTL and testbench

Sequencer for one leaky integrate-and-fire neuron. It accepts signed input-current samples over a valid/ready handshake and owns the membrane-potential register. Each sample goes through a leak-then-integrate update, and the block fires a one-cycle spike on threshold crossing. It drives the 2:1 signed mux select that chooses between the updated potential and the reset potential, then enforces a refractory window.

---
 rtl/lif_neuron_ctrl_pkg.sv | 22 ++
 rtl/MUX_2.sv | 11 +
 rtl/lif_neuron_ctrl.sv | 86 ++++++++
 tb/tb_lif_neuron_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lif_neuron_ctrl_pkg.sv
// Shared definitions for the LIF neuron sequencer: state encodings,
// default datapath width and the saturation helper.
package lif_neuron_ctrl_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] INTEGRATE = 2'd1;
    localparam logic [1:0] FIRE      = 2'd2;
    localparam logic [1:0] REFRAC    = 2'd3;

    localparam int LIF_WIDTH = 12;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi, lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi)      sat = hi;
        else if (x < lo) sat = lo;
        else             sat = x;
    endfunction

endpackage

// File: rtl/MUX_2.sv
// Generic 2:1 signed word mux: sel=0 passes a, sel=1 passes b.
module MUX_2 #(
    parameter int W = 12
) (
    input  logic                sel,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/lif_neuron_ctrl.sv
// Leaky integrate-and-fire neuron sequencer: leak-then-integrate update,
// one-cycle spike on threshold, reset-potential load and refractory window.
module lif_neuron_ctrl
    import lif_neuron_ctrl_pkg::*;
#(
    parameter int WIDTH         = LIF_WIDTH,
    parameter int THRESH        = 512,
    parameter int V_RESET       = 0,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRAC_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_current,
    output logic                    spike,
    output logic signed [WIDTH-1:0] v_mem,
    output logic                    mux_sel,
    output logic                    refractory
);

    localparam int CW = $clog2(REFRAC_CYCLES + 2);
    localparam logic signed [WIDTH-1:0] VRST  = WIDTH'(V_RESET);
    localparam logic        [CW-1:0]    RLOAD = CW'(REFRAC_CYCLES);

    logic [1:0]              state, state_nxt;
    logic signed [WIDTH-1:0] cur_q, v_next, v_d;
    logic [CW-1:0]           cnt;
    logic signed [WIDTH+1:0] v_ext, c_ext, v_wide;
    logic signed [31:0]      v_sat;
    logic                    fire_now, v_en;

    // Two guard bits cover the worst-case leak/add excursion before clamping.
    assign v_ext    = {{2{v_mem[WIDTH-1]}}, v_mem};
    assign c_ext    = {{2{cur_q[WIDTH-1]}}, cur_q};
    assign v_wide   = v_ext - (v_ext >>> LEAK_SHIFT) + c_ext;
    assign v_sat    = sat({{(30-WIDTH){v_wide[WIDTH+1]}}, v_wide}, WIDTH);
    assign v_next   = v_sat[WIDTH-1:0];
    assign fire_now = (v_sat >= THRESH);

    assign in_ready   = (state == IDLE) || (state == REFRAC);
    assign spike      = (state == FIRE);
    assign mux_sel    = (state == FIRE);
    assign refractory = (state == REFRAC);
    assign v_en       = (state == INTEGRATE) || (state == FIRE);

    MUX_2 #(.W(WIDTH)) u_vmux (
        .sel (mux_sel),
        .a   (v_next),
        .b   (VRST),
        .y   (v_d)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (in_valid) state_nxt = INTEGRATE;
            INTEGRATE: state_nxt = fire_now ? FIRE : IDLE;
            FIRE:      state_nxt = (REFRAC_CYCLES == 0) ? IDLE : REFRAC;
            REFRAC:    if (cnt <= CW'(1)) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            v_mem <= VRST;
            cur_q <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid)
                cur_q <= in_current;
            if (v_en)
                v_mem <= v_d;
            // Samples taken during REFRAC are handshaken but never captured.
            if (state == FIRE)
                cnt <= RLOAD;
            else if (state == REFRAC && cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_lif_neuron_ctrl.sv
// Bench for lif_neuron_ctrl: directed scenarios plus random samples checked
// against an arithmetic model of the membrane potential and firing timing.
module tb_lif_neuron_ctrl;

    localparam int W = 12, TH = 512, VR = 0, LS = 3, RC = 4;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, spike, mux_sel, refractory;
    logic signed [W-1:0] in_current, v_mem;
    logic in_valid0, in_ready0, spike0, mux_sel0, refractory0;
    logic signed [W-1:0] in_current0, v_mem0;

    int checks = 0;
    int errors = 0;
    int mv = 0;
    int last_cur = 0;

    always #5 clk = ~clk;

    lif_neuron_ctrl #(.WIDTH(W), .THRESH(TH), .V_RESET(VR), .LEAK_SHIFT(LS), .REFRAC_CYCLES(RC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_current(in_current),
        .spike(spike), .v_mem(v_mem), .mux_sel(mux_sel), .refractory(refractory)
    );

    lif_neuron_ctrl #(.WIDTH(W), .THRESH(TH), .V_RESET(VR), .LEAK_SHIFT(LS), .REFRAC_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_current(in_current0),
        .spike(spike0), .v_mem(v_mem0), .mux_sel(mux_sel0), .refractory(refractory0)
    );

    function automatic int m_sat(input int x);
        if (x > 2047) return 2047;
        if (x < -2048) return -2048;
        return x;
    endfunction

    // Floor division by 2^LS, i.e. arithmetic shift rounding toward -inf.
    function automatic int m_leak(input int x);
        int d, r;
        d = 1 << LS;
        r = ((x % d) + d) % d;
        return (x - r) / d;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_v", v_mem, VR);
        chk("rst_spk", spike, 0);
        chk("rst_sel", mux_sel, 0);
        chk("rst_ref", refractory, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_rdy", in_ready, 1);
        mv = VR;
    endtask

    // Present a sample, wait for the accepting edge, then scramble the bus.
    task automatic accept(input int val);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rdy_wait", in_ready, 1);
        in_valid   = 1'b1;
        in_current = W'(val);
        last_cur   = val;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_current = W'($urandom);
        chk("integ_rdy", in_ready, 0);
        chk("integ_spk", spike, 0);
        chk("integ_sel", mux_sel, 0);
    endtask

    task automatic finish_txn(input bit stuff);
        int ev;
        bit f;
        @(posedge clk); #1;
        ev = m_sat(mv - m_leak(mv) + last_cur);
        f  = (ev >= TH);
        chk("v_upd", v_mem, ev);
        chk("spike", spike, f);
        chk("sel", mux_sel, f);
        if (f) begin
            chk("fire_rdy", in_ready, 0);
            mv = VR;
            @(posedge clk); #1;
            for (int i = 0; i < RC; i++) begin
                chk("ref_flag", refractory, 1);
                chk("ref_rdy", in_ready, 1);
                chk("ref_v", v_mem, VR);
                chk("ref_spk", spike, 0);
                if (stuff) begin
                    in_valid   = 1'b1;
                    in_current = W'($urandom);
                end
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            chk("post_ref", refractory, 0);
            chk("post_rdy", in_ready, 1);
            chk("post_v", v_mem, VR);
        end else begin
            mv = ev;
            chk("idle_rdy", in_ready, 1);
        end
    endtask

    initial begin
        int c;
        rst = 1'b1; in_valid = 1'b0; in_current = '0; in_valid0 = 1'b0; in_current0 = '0;
        #2;
        do_reset();

        // 1: held valid, one accept per two cycles, 100 then 188
        in_valid = 1'b1; in_current = 12'sd100;
        chk("t1_rdy0", in_ready, 1);
        @(posedge clk); #1;
        chk("t1_rdy1", in_ready, 0);
        chk("t1_v0", v_mem, 0);
        @(posedge clk); #1;
        chk("t1_v1", v_mem, 100);
        chk("t1_rdy2", in_ready, 1);
        chk("t1_spk1", spike, 0);
        @(posedge clk); #1;
        chk("t1_rdy3", in_ready, 0);
        @(posedge clk); #1;
        chk("t1_v2", v_mem, 188);
        chk("t1_spk2", spike, 0);
        in_valid = 1'b0;
        mv = 188;

        // 2 and 3: fire, then fire with samples stuffed into REFRAC, then 50
        do_reset();
        accept(600); finish_txn(1'b0);
        accept(600); finish_txn(1'b1);
        accept(50);  finish_txn(1'b0);
        chk("t3_v50", v_mem, 50);

        // 4: threshold boundary and saturation
        do_reset();
        accept(511); finish_txn(1'b0);
        chk("t4_511", v_mem, 511);
        do_reset();
        accept(512); finish_txn(1'b0);
        accept(-2048); finish_txn(1'b0);
        accept(-2048); finish_txn(1'b0);
        chk("t4_neg_sat", v_mem, -2048);
        accept(2047); finish_txn(1'b0);
        accept(2047); finish_txn(1'b0);

        // 5: reset during INTEGRATE and mid-REFRAC
        accept(300);
        rst = 1'b1; #1;
        chk("t5a_v", v_mem, 0); chk("t5a_rdy", in_ready, 1);
        chk("t5a_spk", spike, 0); chk("t5a_sel", mux_sel, 0); chk("t5a_ref", refractory, 0);
        #3 rst = 1'b0;
        mv = VR;
        @(posedge clk); #1;
        accept(100); finish_txn(1'b0);
        chk("t5a_100", v_mem, 100);
        mv = 0;
        do_reset();
        accept(700);
        @(posedge clk); #1;
        chk("t5b_spk", spike, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5b_inref", refractory, 1);
        rst = 1'b1; #1;
        chk("t5b_ref", refractory, 0); chk("t5b_rdy", in_ready, 1);
        chk("t5b_v", v_mem, 0); chk("t5b_spk0", spike, 0); chk("t5b_sel", mux_sel, 0);
        #3 rst = 1'b0;
        mv = VR;
        @(posedge clk); #1;
        accept(100); finish_txn(1'b0);
        chk("t5b_100", v_mem, 100);

        // random samples against the model
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) c = int'($urandom_range(0, 4095)) - 2048;
            else                           c = int'($urandom_range(0, 700)) - 200;
            accept(c);
            finish_txn(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        // 6: zero-length refractory on the second instance
        in_valid0 = 1'b1; in_current0 = 12'sd600;
        @(posedge clk); #1;
        in_valid0 = 1'b0; in_current0 = 12'sd0;
        @(posedge clk); #1;
        chk("t6_spk", spike0, 1);
        chk("t6_v", v_mem0, 600);
        @(posedge clk); #1;
        chk("t6_rdy", in_ready0, 1);
        chk("t6_ref", refractory0, 0);
        chk("t6_spk0", spike0, 0);
        chk("t6_vrst", v_mem0, 0);
        in_valid0 = 1'b1; in_current0 = 12'sd50;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        @(posedge clk); #1;
        chk("t6_v50", v_mem0, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
